// File: rtl/cga_mac_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : cga_mac_pkg                                                    |
// | Purpose : Shared constants and types for the MAC control-address path.   |
// |           The control-address width and the default return-stack depth   |
// |           are defined here, together with the parity helper used by the  |
// |           optional parity build (CGA_MAC_RSTACK_PARITY_EN).              |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package cga_mac_pkg;

    localparam int CGA_MAC_AW                   = 16;
    localparam int CGA_MAC_RSTACK_DEPTH_DEFAULT = 4;

    typedef logic [CGA_MAC_AW-1:0] cga_mac_addr_t;

    // Stored bit that makes {data, bit} contain an odd number of ones.
    function automatic logic odd_par(input cga_mac_addr_t d);
        return ~(^d);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cga_mac_rstack_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : cga_mac_rstack_if                                            |
// | Purpose   : Control/data bundle of the microprogram return stack.        |
// |   master : drives MCLK, HOLD, PUSH, POP, LOAD, CLRERR, NLCA_15_0,        |
// |            CD_15_0 (and force_perr with CGA_MAC_RSTACK_PARITY_EN);       |
// |            observes PR_15_0, EMPTY, FULL, OVF, UNF, PERR.                |
// |   slave  : the stack itself (directions reversed).                       |
// | Rev       : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
interface cga_mac_rstack_if;
    import cga_mac_pkg::*;

    logic          MCLK;
    logic          HOLD;
    logic          PUSH;
    logic          POP;
    logic          LOAD;
    logic          CLRERR;
    cga_mac_addr_t NLCA_15_0;
    cga_mac_addr_t CD_15_0;
    cga_mac_addr_t PR_15_0;
    logic          EMPTY;
    logic          FULL;
    logic          OVF;
    logic          UNF;
    logic          PERR;
`ifdef CGA_MAC_RSTACK_PARITY_EN
    logic          force_perr;
`endif

    modport master (
`ifdef CGA_MAC_RSTACK_PARITY_EN
        output force_perr,
`endif
        output MCLK, HOLD, PUSH, POP, LOAD, CLRERR, NLCA_15_0, CD_15_0,
        input  PR_15_0, EMPTY, FULL, OVF, UNF, PERR
    );

    modport slave (
`ifdef CGA_MAC_RSTACK_PARITY_EN
        input  force_perr,
`endif
        input  MCLK, HOLD, PUSH, POP, LOAD, CLRERR, NLCA_15_0, CD_15_0,
        output PR_15_0, EMPTY, FULL, OVF, UNF, PERR
    );

endinterface
`default_nettype wire

// File: rtl/cga_mac_rstack_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : cga_mac_rstack_mem                                             |
// | Purpose : DEPTH x W register file, one synchronous write port and one    |
// |           combinational read port. Cleared by synchronous reset.         |
// | Ports   : clk, rst          clock / synchronous active-high reset        |
// |           we, waddr, wdata  write port                                   |
// |           raddr, rdata      asynchronous read port                       |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module cga_mac_rstack_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     we,
    input  wire logic [$clog2(DEPTH)-1:0] waddr,
    input  wire logic [W-1:0]             wdata,
    input  wire logic [$clog2(DEPTH)-1:0] raddr,
    output logic      [W-1:0]             rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/cga_mac_rstack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : cga_mac_rstack                                                 |
// | Purpose : Microprogram return-address stack for the MAC address path.    |
// |           PUSH saves NLCA, POP returns, LOAD rewrites the top entry from |
// |           CD. PR_15_0 shows the current top (0 when empty) and feeds the |
// |           PSEL leg of the ICA mux. State moves only on sysclk edges with |
// |           MCLK=1 and HOLD=0, in step with the downstream LCA register.   |
// | Ports   : sysclk, sys_rst  clock / synchronous active-high reset         |
// |           bus (slave)      controls, NLCA/CD in; PR, EMPTY, FULL, OVF,   |
// |                            UNF, PERR out                                 |
// | Macro   : CGA_MAC_RSTACK_PARITY_EN adds an odd-parity bit per entry and  |
// |           drives PERR; otherwise PERR is tied to 0.                      |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module cga_mac_rstack
    import cga_mac_pkg::*;
#(
    parameter int DEPTH = CGA_MAC_RSTACK_DEPTH_DEFAULT,
    parameter int AW    = CGA_MAC_AW
) (
    input  wire logic        sysclk,
    input  wire logic        sys_rst,
    cga_mac_rstack_if.slave  bus
);

    localparam int c_TPW = $clog2(DEPTH);
    localparam int c_CW  = $clog2(DEPTH + 1);
    localparam logic [c_CW-1:0] c_FULL_CNT = c_CW'(DEPTH);
`ifdef CGA_MAC_RSTACK_PARITY_EN
    localparam int c_MW = AW + 1;
`else
    localparam int c_MW = AW;
`endif

    logic [c_TPW-1:0] r_tp, w_tp_nxt, w_tp_inc, w_waddr;
    logic [c_CW-1:0]  r_cnt, w_cnt_nxt;
    logic             r_ovf, r_unf, w_ovf_nxt, w_unf_nxt;
    logic             w_en, w_we, w_empty, w_full;
    logic [AW-1:0]    w_wval;
    logic [c_MW-1:0]  w_wdata, w_rdata;

    assign w_en     = bus.MCLK & ~bus.HOLD;
    assign w_empty  = (r_cnt == '0);
    assign w_full   = (r_cnt == c_FULL_CNT);
    assign w_tp_inc = r_tp + c_TPW'(1);

    // Operation priority: PUSH&POP, PUSH, POP, LOAD. A push into a full
    // stack wraps onto the oldest slot; count saturates at DEPTH.
    always_comb begin
        w_we      = 1'b0;
        w_waddr   = r_tp;
        w_wval    = bus.NLCA_15_0;
        w_tp_nxt  = r_tp;
        w_cnt_nxt = r_cnt;
        w_ovf_nxt = r_ovf;
        w_unf_nxt = r_unf;
        if (w_en) begin
            if (bus.PUSH && bus.POP) begin
                w_we = 1'b1;
                if (w_empty) begin
                    w_waddr   = w_tp_inc;
                    w_tp_nxt  = w_tp_inc;
                    w_cnt_nxt = r_cnt + c_CW'(1);
                    w_unf_nxt = 1'b1;
                end
            end else if (bus.PUSH) begin
                w_we     = 1'b1;
                w_waddr  = w_tp_inc;
                w_tp_nxt = w_tp_inc;
                if (w_full) begin
                    w_ovf_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_CW'(1);
                end
            end else if (bus.POP) begin
                if (w_empty) begin
                    w_unf_nxt = 1'b1;
                end else begin
                    w_tp_nxt  = r_tp - c_TPW'(1);
                    w_cnt_nxt = r_cnt - c_CW'(1);
                end
            end else if (bus.LOAD) begin
                w_we   = 1'b1;
                w_wval = bus.CD_15_0;
                if (w_empty) begin
                    w_waddr   = w_tp_inc;
                    w_tp_nxt  = w_tp_inc;
                    w_cnt_nxt = r_cnt + c_CW'(1);
                end
            end
            // Clear wins over any set in the same microcycle.
            if (bus.CLRERR) begin
                w_ovf_nxt = 1'b0;
                w_unf_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            r_tp  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_tp  <= w_tp_nxt;
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_ovf_nxt;
            r_unf <= w_unf_nxt;
        end
    end

`ifdef CGA_MAC_RSTACK_PARITY_EN
    // force_perr flips the stored parity bit to plant a detectable error.
    assign w_wdata  = {odd_par(w_wval) ^ bus.force_perr, w_wval};
    assign bus.PERR = ~w_empty & ~(^w_rdata);
`else
    assign w_wdata  = w_wval;
    assign bus.PERR = 1'b0;
`endif

    cga_mac_rstack_mem #(
        .DEPTH (DEPTH),
        .W     (c_MW)
    ) u_mem (
        .clk   (sysclk),
        .rst   (sys_rst),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (w_wdata),
        .raddr (r_tp),
        .rdata (w_rdata)
    );

    assign bus.PR_15_0 = w_empty ? '0 : w_rdata[AW-1:0];
    assign bus.EMPTY   = w_empty;
    assign bus.FULL    = w_full;
    assign bus.OVF     = r_ovf;
    assign bus.UNF     = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_cga_mac_rstack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_cga_mac_rstack                                              |
// | Purpose : Self-checking bench for cga_mac_rstack (DEPTH=4): directed     |
// |           vector table, parity sequence when CGA_MAC_RSTACK_PARITY_EN is |
// |           defined, then random stimulus against a queue-based model.     |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_cga_mac_rstack;

    localparam int c_DEPTH = 4;

    typedef struct {
        bit          push, pop, load, mclk, hold, clr;
        logic [15:0] nlca, cd, pr;
        bit          empty, full, ovf, unf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    cga_mac_rstack_if bus ();

    cga_mac_rstack #(.DEPTH(c_DEPTH), .AW(16)) dut (
        .sysclk  (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model: stack as a queue of {parity_bad, value}, newest last.
    bit [16:0] mq[$];
    bit        m_ovf, m_unf;

    function automatic vec_t mk(bit push, bit pop, bit load, bit mclk, bit hold, bit clr,
                                logic [15:0] nlca, logic [15:0] cd, logic [15:0] pr,
                                bit empty, bit full, bit ovf, bit unf);
        vec_t v;
        v.push = push; v.pop = pop; v.load = load; v.mclk = mclk; v.hold = hold; v.clr = clr;
        v.nlca = nlca; v.cd = cd; v.pr = pr;
        v.empty = empty; v.full = full; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [20:0] act, input logic [20:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual={PR,E,F,O,U,P}=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [20:0] dut_obs();
        return {bus.PR_15_0, bus.EMPTY, bus.FULL, bus.OVF, bus.UNF, bus.PERR};
    endfunction

    task automatic model_step();
        bit fp;
`ifdef CGA_MAC_RSTACK_PARITY_EN
        fp = bus.force_perr;
`else
        fp = 1'b0;
`endif
        if (rst) begin
            mq.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (bus.MCLK && !bus.HOLD) begin
            if (bus.PUSH && bus.POP) begin
                if (mq.size() > 0) mq[mq.size()-1] = {fp, bus.NLCA_15_0};
                else begin
                    mq.push_back({fp, bus.NLCA_15_0});
                    m_unf = 1;
                end
            end else if (bus.PUSH) begin
                if (mq.size() == c_DEPTH) begin
                    void'(mq.pop_front());
                    m_ovf = 1;
                end
                mq.push_back({fp, bus.NLCA_15_0});
            end else if (bus.POP) begin
                if (mq.size() > 0) void'(mq.pop_back());
                else m_unf = 1;
            end else if (bus.LOAD) begin
                if (mq.size() > 0) mq[mq.size()-1] = {fp, bus.CD_15_0};
                else mq.push_back({fp, bus.CD_15_0});
            end
            if (bus.CLRERR) begin
                m_ovf = 0;
                m_unf = 0;
            end
        end
    endtask

    function automatic logic [20:0] model_obs();
        logic [15:0] pr;
        bit          pe;
        pr = (mq.size() > 0) ? mq[mq.size()-1][15:0] : 16'h0000;
        pe = (mq.size() > 0) ? mq[mq.size()-1][16] : 1'b0;
        return {pr, mq.size() == 0, mq.size() == c_DEPTH, m_ovf, m_unf, pe};
    endfunction

    vec_t tbl[$];

    initial begin
        rst = 1'b1;
        bus.MCLK = 1'b1; bus.HOLD = 1'b0; bus.PUSH = 1'b1; bus.POP = 1'b0;
        bus.LOAD = 1'b0; bus.CLRERR = 1'b0; bus.NLCA_15_0 = 16'h5A5A; bus.CD_15_0 = 16'h0;
`ifdef CGA_MAC_RSTACK_PARITY_EN
        bus.force_perr = 1'b0;
`endif

        //                push pop load mclk hold clr  nlca      cd        pr       E F O U
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 16'h0101, 16'h0000, 16'h0101, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 16'h0202, 16'h0000, 16'h0202, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 16'h0303, 16'h0000, 16'h0303, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0202, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0101, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 16'h1000, 16'h0000, 16'h1000, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 16'h2000, 16'h0000, 16'h2000, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 16'h3000, 16'h0000, 16'h3000, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 16'h4000, 16'h0000, 16'h4000, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 16'h5000, 16'h0000, 16'h5000, 0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h4000, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h3000, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h2000, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 1, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 16'h0ABC, 16'h0000, 16'h0000, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 16'h0ABC, 16'h0000, 16'h0000, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 16'h0ABC, 16'h0000, 16'h0ABC, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 16'h0DEF, 16'h0000, 16'h0DEF, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 16'h0000, 16'h1234, 16'h1234, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 16'h0000, 16'h5555, 16'h0000, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 16'h0000, 16'h7777, 16'h7777, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 16'h0E0E, 16'h0000, 16'h0E0E, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 1, 16'h0F0F, 16'h0000, 16'h0F0F, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0E0E, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0));

        // Reset dominates MCLK and a pending PUSH.
        repeat (2) @(posedge clk);
        #1;
        chk("reset", dut_obs(), {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        rst = 1'b0;

        foreach (tbl[i]) begin
            bus.PUSH = tbl[i].push; bus.POP = tbl[i].pop; bus.LOAD = tbl[i].load;
            bus.MCLK = tbl[i].mclk; bus.HOLD = tbl[i].hold; bus.CLRERR = tbl[i].clr;
            bus.NLCA_15_0 = tbl[i].nlca; bus.CD_15_0 = tbl[i].cd;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), dut_obs(),
                {tbl[i].pr, tbl[i].empty, tbl[i].full, tbl[i].ovf, tbl[i].unf, 1'b0});
        end

`ifdef CGA_MAC_RSTACK_PARITY_EN
        bus.MCLK = 1'b1; bus.HOLD = 1'b0; bus.LOAD = 1'b0; bus.CLRERR = 1'b0;
        bus.PUSH = 1'b1; bus.POP = 1'b0; bus.NLCA_15_0 = 16'h00FF; bus.force_perr = 1'b1;
        @(posedge clk);
        #1;
        chk("perr_push", dut_obs(), {16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        bus.force_perr = 1'b0; bus.PUSH = 1'b0; bus.POP = 1'b1;
        @(posedge clk);
        #1;
        chk("perr_pop", dut_obs(), {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
`endif

        // Random phase: start from reset so the model is aligned.
        rst = 1'b1;
        model_step();
        @(posedge clk);
        #1;
        chk("rand_reset", dut_obs(), model_obs());
        for (int i = 0; i < 400; i++) begin
            rst           = ($urandom_range(0, 59) == 0);
            bus.MCLK      = ($urandom_range(0, 3) != 0);
            bus.HOLD      = ($urandom_range(0, 4) == 0);
            bus.PUSH      = ($urandom_range(0, 1) == 1);
            bus.POP       = ($urandom_range(0, 1) == 1);
            bus.LOAD      = ($urandom_range(0, 3) == 0);
            bus.CLRERR    = ($urandom_range(0, 7) == 0);
            bus.NLCA_15_0 = 16'($urandom);
            bus.CD_15_0   = 16'($urandom);
`ifdef CGA_MAC_RSTACK_PARITY_EN
            bus.force_perr = ($urandom_range(0, 7) == 0);
`endif
            model_step();
            @(posedge clk);
            #1;
            chk($sformatf("rand%0d", i), dut_obs(), model_obs());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cga_mac_rstack.md
Name: cga_mac_rstack

Overview:
- Microprogram return-address stack for the MAC address path.
- On a micro-call it captures the incremented control address (NLCA) and presents the current top of stack on PR_15_0.
- PR_15_0 feeds the PSEL leg of the ICA address mux in the next cycle.
- Updates only on MCLK-qualified sysclk edges and freezes under HOLD, in step with the LCA register downstream.

Parameters:
- DEPTH, 4, number of 16-bit return entries (power of two, 2..16).
- AW, 16, address width; fixed by the ICA/LCA path.

Ports:
- sysclk  in  1  system clock.
- sys_rst  in  1  synchronous, active-high reset.
- MCLK  in  1  microcycle enable; state changes only on sysclk edges where MCLK=1.
- HOLD  in  1  freeze; when 1, no state change even if MCLK=1.
- PUSH  in  1  micro-call: push NLCA_15_0.
- POP  in  1  micro-return: pop top entry.
- LOAD  in  1  replace top entry with CD_15_0 (microcode write of return address).
- NLCA_15_0  in  16  incremented current control address.
- CD_15_0  in  16  control data bus.
- CLRERR  in  1  clears the sticky error flags.
- PR_15_0  out  16  top-of-stack value; 0 when empty.
- EMPTY  out  1  count==0.
- FULL  out  1  count==DEPTH.
- OVF  out  1  sticky; a push occurred while full.
- UNF  out  1  sticky; a pop occurred while empty.
- PERR  out  1  parity error on the top entry (see Optional Feature).

Behaviour:
- State:
  - entry[DEPTH] of AW bits.
  - top index tp, log2(DEPTH) bits, circular.
  - count, 0..DEPTH.
- Reset (sys_rst=1 on any sysclk edge, regardless of MCLK/HOLD):
  - tp=0, count=0, OVF=0, UNF=0.
  - All entries cleared to 0.
  - Outputs after reset: PR=0, EMPTY=1, FULL=0, PERR=0.
- Update condition: en = MCLK & ~HOLD & ~sys_rst. If en=0, all state holds.
- Operation priority when en=1, evaluated in this order:
  1. PUSH & POP (call replacing return):
     - count>0: entry[tp] <= NLCA; tp and count unchanged.
     - count==0: treat as PUSH and set UNF.
  2. PUSH:
     - tp <= tp+1 (mod DEPTH); entry[tp+1] <= NLCA.
     - count <= min(count+1, DEPTH).
     - If count==DEPTH beforehand, the oldest entry is overwritten and OVF is set.
  3. POP:
     - count>0: tp <= tp-1 (mod DEPTH); count <= count-1.
     - count==0: no change to tp/count; UNF set.
  4. LOAD (ignored whenever PUSH or POP is asserted):
     - count>0: entry[tp] <= CD.
     - count==0: acts as a push of CD.
  5. CLRERR: OVF and UNF are cleared in the same cycle, after the set terms. A set and a CLRERR in the same cycle leave the flag 0.
- Output timing:
  - PR_15_0 = (count==0) ? 0 : entry[tp]. It is a combinational read of registered state, so there is no added latency.
  - A push is visible on PR in the cycle after the enabled edge.
  - EMPTY, FULL, OVF and UNF are registered state or a direct decode of it.
- Wrap-around: tp wraps modulo DEPTH. count saturates at DEPTH and never goes below 0.
- A HOLD asserted mid-sequence stalls exactly one microcycle per held edge. No operation is lost or duplicated as long as PUSH/POP stay stable while HOLD=1.

Optional Feature:
- Macro: CGA_MAC_RSTACK_PARITY_EN.
- Defined:
  - Each entry stores an odd-parity bit computed at write time.
  - PERR = (count>0) & (parity of entry[tp] plus its stored bit is not odd).
  - A test hook force_perr (wire) inverts the stored bit on the next write.
- Undefined: no parity storage; PERR is tied to 0; the port remains.

Decomposition:
- Shared package cga_mac_pkg:
  - CGA_MAC_AW = 16.
  - CGA_MAC_RSTACK_DEPTH_DEFAULT = 4.
  - Typedef for a 16-bit control address.
- One natural sub-module: cga_mac_rstack_mem. DEPTH x (AW[+1]) register file with one synchronous write port and one combinational read port addressed by tp.
- Pointer, count, flag and priority logic stays in cga_mac_rstack.

Test Plan:
- Reset then idle:
  - sys_rst high for 2 edges with MCLK=1 -> PR=0000, EMPTY=1, FULL=0, OVF=0, UNF=0.
- Nested calls and returns:
  - PUSH with NLCA=0101, then 0202, then 0303 -> PR=0303.
  - POP -> PR=0202; POP -> PR=0101; POP -> PR=0000, EMPTY=1.
- Overflow at DEPTH=4:
  - Push 1000, 2000, 3000, 4000 -> FULL=1.
  - Push 5000 -> OVF=1, PR=5000.
  - Four POPs -> PR sequence 4000, 3000, 2000, then 0000 with EMPTY=1. The 1000 entry is lost.
- Underflow and clear:
  - POP when empty -> UNF=1, PR=0000, count unchanged.
  - CLRERR -> UNF=0.
  - POP+CLRERR in the same cycle -> UNF=0.
- Enable, HOLD and precedence:
  - PUSH 0ABC with MCLK=0 -> no change.
  - With HOLD=1, MCLK=1 -> no change.
  - HOLD=0 -> PR=0ABC.
  - PUSH+POP with NLCA=0DEF -> PR=0DEF, count unchanged.
  - LOAD with CD=1234 -> PR=1234.
  - LOAD+POP -> pop only.
- Parity (macro defined):
  - force_perr during PUSH 00FF -> PERR=1 while 00FF is on top.
  - POP -> PERR=0.
